// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and lane constants.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } lsu_state_t;

    // Byte offset to bit shift: offset * 8.
    localparam int unsigned LANE_SHIFT = 3;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: store byte enables and data replication,
// load lane extraction with sign/zero extension, and alignment checking.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] lane;

    always_comb begin
        lane       = raw_rdata >> (5'(addr_lo) << LANE_SHIFT);
        be         = '0;
        wdata_rep  = wdata;
        load_data  = lane;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                be        = BE_BYTE << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_data = {{24{lane[7] & ~load_unsigned}}, lane[7:0]};
            end
            SZ_HALF: begin
                be         = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_rep  = {2{wdata[15:0]}};
                load_data  = {{16{lane[15] & ~load_unsigned}}, lane[15:0]};
                misaligned = addr_lo[0];
            end
            SZ_WORD: begin
                be         = BE_WORD;
                misaligned = |addr_lo;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: drives a req/gnt/rvalid data bus from the ALU address,
// stalling the core until the access completes, times out, or is rejected.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256,
    parameter int unsigned TO_W    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    lsu_state_t      state;
    logic [TO_W-1:0] cnt;
    logic            we_q;
    logic [1:0]      addr_lo_q;
    logic [1:0]      size_q;
    logic            uns_q;

    logic            access;
    logic            illegal;
    logic [1:0]      al_addr;
    logic [1:0]      al_size;
    logic            al_uns;
    logic [3:0]      al_be;
    logic [31:0]     al_wdata;
    logic [31:0]     al_load;
    logic            al_misaligned;

    // One aligner serves both phases: live core inputs in IDLE, latched attributes afterwards.
    assign al_addr = (state == ST_IDLE) ? addr[1:0]     : addr_lo_q;
    assign al_size = (state == ST_IDLE) ? size          : size_q;
    assign al_uns  = (state == ST_IDLE) ? load_unsigned : uns_q;

    lsu_align u_align (
        .addr_lo       (al_addr),
        .size          (al_size),
        .load_unsigned (al_uns),
        .wdata         (wdata),
        .raw_rdata     (bus_rdata),
        .be            (al_be),
        .wdata_rep     (al_wdata),
        .load_data     (al_load),
        .misaligned    (al_misaligned)
    );

    assign access  = mem_read | mem_write;
    assign illegal = al_misaligned | (mem_read & mem_write);
    assign stall   = ((state == ST_IDLE) & access & ~illegal)
                   | (state == ST_REQ) | (state == ST_WAIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_lo_q <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        if (illegal) begin
                            err <= 1'b1;
                        end else begin
                            we_q      <= mem_write;
                            addr_lo_q <= addr[1:0];
                            size_q    <= size;
                            uns_q     <= load_unsigned;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_write;
                            bus_addr  <= {addr[31:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (bus_rvalid) begin
                        err   <= bus_err;
                        rdata <= (bus_err | we_q) ? '0 : al_load;
                        state <= ST_DONE;
                    end else if ((TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1))) begin
                        err   <= 1'b1;
                        rdata <= '0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
